// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit MIPS ALU: decodes one instruction per handshake,
// drives the ALU operands for a fixed latency and returns a held response.
module alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic [15:0] Imm,
    output logic [31:0] DataIn1,
    output logic [31:0] DataIn2,
    output logic [3:0]  Operation,
    input  logic [31:0] Result,
    input  logic        Zero,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutResult,
    output logic        OutZero,
    output logic        OutBranch,
    output logic        OutIllegal
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_IDLE = 4'd15;

    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  cnt_r;
    logic        beq_r;
    logic        ill_r;
    logic [3:0]  dec_op_s;
    logic [31:0] dec_b_s;
    logic        dec_ill_s;
    logic        dec_beq_s;
    logic        done_s;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

    // Opcode/funct decode into ALU operation, second operand and instruction class.
    always_comb begin
        dec_op_s  = OP_IDLE;
        dec_b_s   = RtData;
        dec_ill_s = 1'b0;
        dec_beq_s = 1'b0;
        case (Opcode)
            6'h00: begin
                case (Funct)
                    6'h24:   dec_op_s = OP_AND;
                    6'h25:   dec_op_s = OP_OR;
                    6'h20:   dec_op_s = OP_ADD;
                    6'h22:   dec_op_s = OP_SUB;
                    6'h2A:   dec_op_s = OP_SLT;
                    6'h27:   dec_op_s = OP_NOR;
                    default: dec_ill_s = 1'b1;
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin
                dec_op_s = OP_ADD;
                dec_b_s  = sext16(Imm);
            end
            6'h0A: begin
                dec_op_s = OP_SLT;
                dec_b_s  = sext16(Imm);
            end
            6'h0C: begin
                dec_op_s = OP_AND;
                dec_b_s  = zext16(Imm);
            end
            6'h0D: begin
                dec_op_s = OP_OR;
                dec_b_s  = zext16(Imm);
            end
            6'h04: begin
                dec_op_s  = OP_SUB;
                dec_beq_s = 1'b1;
            end
            default: dec_ill_s = 1'b1;
        endcase
    end

    assign done_s = (state_r == ST_EXEC) && (cnt_r == 3'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; illegal requests also pass through EXEC for one cycle
    // so their response appears one edge after acceptance.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (InValid) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (OutReady) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        InReady  = 1'b0;
        OutValid = 1'b0;
        case (state_r)
            ST_IDLE: InReady  = 1'b1;
            ST_EXEC: InReady  = 1'b0;
            ST_RESP: OutValid = 1'b1;
            default: InReady  = 1'b0;
        endcase
    end

    // Operand/operation registers, latency counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 3'd0;
            beq_r      <= 1'b0;
            ill_r      <= 1'b0;
            DataIn1    <= 32'd0;
            DataIn2    <= 32'd0;
            Operation  <= OP_IDLE;
            OutResult  <= 32'd0;
            OutZero    <= 1'b0;
            OutBranch  <= 1'b0;
            OutIllegal <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (InValid) begin
                        beq_r <= dec_beq_s;
                        ill_r <= dec_ill_s;
                        if (dec_ill_s) begin
                            cnt_r <= 3'd0;
                        end else begin
                            cnt_r     <= LAT_INIT;
                            DataIn1   <= RsData;
                            DataIn2   <= dec_b_s;
                            Operation <= dec_op_s;
                        end
                    end
                end
                ST_EXEC: begin
                    if (done_s) begin
                        OutResult  <= ill_r ? 32'd0 : Result;
                        OutZero    <= Zero & ~ill_r;
                        OutBranch  <= beq_r & Zero & ~ill_r;
                        OutIllegal <= ill_r;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (OutReady) begin
                        Operation <= OP_IDLE;
                    end
                end
                default: cnt_r <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a latency-1 instance for the functional
// cases and a latency-3 instance for reset-during-execution.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        br;
        logic        ill;
    } rsp_t;

    logic        clk;
    logic        rst_n, rst3_n;
    logic        InValid, InValid3;
    logic        OutReady, OutReady3;
    logic [5:0]  Opcode, Funct;
    logic [31:0] RsData, RtData;
    logic [15:0] Imm;

    logic        InReady, OutValid, OutZero, OutBranch, OutIllegal;
    logic [31:0] DataIn1, DataIn2, Result, OutResult;
    logic [3:0]  Operation;
    logic        Zero;

    logic        InReady3, OutValid3, OutZero3, OutBranch3, OutIllegal3;
    logic [31:0] DataIn1_3, DataIn2_3, Result3, OutResult3;
    logic [3:0]  Operation3;
    logic        Zero3;

    int n_checks = 0;
    int n_pass   = 0;
    rsp_t sb_q[$];
    rsp_t sb3_q[$];

    alu_issue_ctrl #(.ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .Opcode(Opcode), .Funct(Funct), .RsData(RsData), .RtData(RtData), .Imm(Imm),
        .DataIn1(DataIn1), .DataIn2(DataIn2), .Operation(Operation),
        .Result(Result), .Zero(Zero), .OutValid(OutValid), .OutReady(OutReady),
        .OutResult(OutResult), .OutZero(OutZero), .OutBranch(OutBranch), .OutIllegal(OutIllegal)
    );

    alu_issue_ctrl #(.ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .InValid(InValid3), .InReady(InReady3),
        .Opcode(Opcode), .Funct(Funct), .RsData(RsData), .RtData(RtData), .Imm(Imm),
        .DataIn1(DataIn1_3), .DataIn2(DataIn2_3), .Operation(Operation3),
        .Result(Result3), .Zero(Zero3), .OutValid(OutValid3), .OutReady(OutReady3),
        .OutResult(OutResult3), .OutZero(OutZero3), .OutBranch(OutBranch3), .OutIllegal(OutIllegal3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // ALU models: registered for the latency-1 instance, combinational for latency-3
    // (its operands are held for the whole execution window).
    always @(posedge clk) begin
        Result <= alu_f(Operation, DataIn1, DataIn2);
        Zero   <= (alu_f(Operation, DataIn1, DataIn2) == 32'd0);
    end
    assign Result3 = alu_f(Operation3, DataIn1_3, DataIn2_3);
    assign Zero3   = (Result3 == 32'd0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    rsp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && OutValid && OutReady) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_result",  OutResult,          mon_e.res);
                check("rsp_zero",    32'(OutZero),       32'(mon_e.z));
                check("rsp_branch",  32'(OutBranch),     32'(mon_e.br));
                check("rsp_illegal", 32'(OutIllegal),    32'(mon_e.ill));
            end
        end
    end

    rsp_t mon3_e;
    always @(negedge clk) begin
        if (rst3_n && OutValid3 && OutReady3) begin
            if (sb3_q.size() == 0) begin
                check("sb3_unexpected", 32'd1, 32'd0);
            end else begin
                mon3_e = sb3_q.pop_front();
                check("rsp3_result",  OutResult3,       mon3_e.res);
                check("rsp3_zero",    32'(OutZero3),    32'(mon3_e.z));
                check("rsp3_branch",  32'(OutBranch3),  32'(mon3_e.br));
                check("rsp3_illegal", 32'(OutIllegal3), 32'(mon3_e.ill));
            end
        end
    end

    // Called just after a falling edge; returns 1 time unit after the accept edge.
    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm, input rsp_t e);
        Opcode = op; Funct = fn; RsData = rs; RtData = rt; Imm = imm;
        check("in_ready_idle", 32'(InReady), 32'd1);
        check("op_idle", 32'(Operation), 32'd15);
        sb_q.push_back(e);
        InValid = 1'b1;
        @(posedge clk);
        #1 InValid = 1'b0;
    endtask

    // n = falling edges waited; OutValid first seen at falling edge n means high from edge k+n-1.
    task automatic wait_rsp(output int n, output logic [3:0] opv, output logic [31:0] d2);
        n = 0; opv = 4'hF; d2 = 32'd0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                opv = Operation;
                d2  = DataIn2;
            end
        end while (!OutValid && n < 20);
        if (!OutValid) check("rsp_timeout", 32'(OutValid), 32'd1);
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                       input rsp_t e, input int exp_n, input logic [3:0] exp_op, input logic [31:0] exp_d2);
        int n; logic [3:0] opv; logic [31:0] d2;
        @(negedge clk);
        send(op, fn, rs, rt, imm, e);
        wait_rsp(n, opv, d2);
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
        check({tag, "_op"}, 32'(opv), 32'(exp_op));
        check({tag, "_din2"}, d2, exp_d2);
    endtask

    initial begin
        int n; logic [3:0] opv; logic [31:0] d2; int spurious;
        rst_n = 1'b0; rst3_n = 1'b0;
        InValid = 1'b0; InValid3 = 1'b0;
        OutReady = 1'b1; OutReady3 = 1'b1;
        Opcode = 6'd0; Funct = 6'd0; RsData = 32'd0; RtData = 32'd0; Imm = 16'd0;
        #12;
        check("rst_inready",  32'(InReady),    32'd1);
        check("rst_outvalid", 32'(OutValid),   32'd0);
        check("rst_op",       32'(Operation),  32'd15);
        check("rst_din1",     DataIn1,         32'd0);
        check("rst_din2",     DataIn2,         32'd0);
        check("rst_outres",   OutResult,       32'd0);
        check("rst_outflags", {29'd0, OutZero, OutBranch, OutIllegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;

        run("add",    6'h00, 6'h20, 32'h5, 32'h7, 16'h0, '{32'hC, 1'b0, 1'b0, 1'b0}, 3, 4'd2, 32'h7);
        run("beq_t",  6'h04, 6'h00, 32'h12345678, 32'h12345678, 16'h0, '{32'h0, 1'b1, 1'b1, 1'b0}, 3, 4'd6, 32'h12345678);
        run("beq_nt", 6'h04, 6'h00, 32'h1, 32'h2, 16'h0, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}, 3, 4'd6, 32'h2);
        run("addi",   6'h08, 6'h00, 32'h10, 32'h0, 16'hFFFF, '{32'hF, 1'b0, 1'b0, 1'b0}, 3, 4'd2, 32'hFFFFFFFF);
        run("ori",    6'h0D, 6'h00, 32'h0, 32'h0, 16'h8000, '{32'h8000, 1'b0, 1'b0, 1'b0}, 3, 4'd1, 32'h00008000);
        run("slti",   6'h0A, 6'h00, 32'hFFFFFFFE, 32'h0, 16'h0001, '{32'h1, 1'b0, 1'b0, 1'b0}, 3, 4'd7, 32'h1);
        run("andi",   6'h0C, 6'h00, 32'hFFFF00FF, 32'h0, 16'hF0F0, '{32'hF0, 1'b0, 1'b0, 1'b0}, 3, 4'd0, 32'h0000F0F0);
        run("sub_z",  6'h00, 6'h22, 32'hA, 32'hA, 16'h0, '{32'h0, 1'b1, 1'b0, 1'b0}, 3, 4'd6, 32'hA);
        run("slt",    6'h00, 6'h2A, 32'hFFFFFFFF, 32'h0, 16'h0, '{32'h1, 1'b0, 1'b0, 1'b0}, 3, 4'd7, 32'h0);
        run("or",     6'h00, 6'h25, 32'hF0, 32'h0F, 16'h0, '{32'hFF, 1'b0, 1'b0, 1'b0}, 3, 4'd1, 32'h0F);
        run("sw",     6'h2B, 6'h00, 32'h100, 32'h0, 16'hFFFC, '{32'hFC, 1'b0, 1'b0, 1'b0}, 3, 4'd2, 32'hFFFFFFFC);
        run("lw",     6'h23, 6'h00, 32'h200, 32'h0, 16'h0010, '{32'h210, 1'b0, 1'b0, 1'b0}, 3, 4'd2, 32'h10);
        // Illegal decodes leave DataIn2 at the previous value (0x10 from lw).
        run("ill_fn", 6'h00, 6'h18, 32'h5, 32'h6, 16'h0, '{32'h0, 1'b0, 1'b0, 1'b1}, 2, 4'd15, 32'h10);
        run("ill_op", 6'h02, 6'h00, 32'h5, 32'h6, 16'h0, '{32'h0, 1'b0, 1'b0, 1'b1}, 2, 4'd15, 32'h10);

        // Backpressure: hold the response, offer a second request meanwhile.
        @(negedge clk);
        OutReady = 1'b0;
        send(6'h00, 6'h20, 32'h1, 32'h1, 16'h0, '{32'h2, 1'b0, 1'b0, 1'b0});
        wait_rsp(n, opv, d2);
        check("bp_lat", 32'(n), 32'd3);
        Opcode = 6'h00; Funct = 6'h22; RsData = 32'h9; RtData = 32'h4;
        InValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(OutValid),  32'd1);
            check("bp_inready",    32'(InReady),   32'd0);
            check("bp_result",     OutResult,      32'h2);
            check("bp_op_held",    32'(Operation), 32'd2);
        end
        sb_q.push_back('{32'h5, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1 OutReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_inready_after", 32'(InReady), 32'd1);
        check("bp_op_idle", 32'(Operation), 32'd15);
        @(posedge clk);
        #1 InValid = 1'b0;
        wait_rsp(n, opv, d2);
        check("bp2_lat", 32'(n), 32'd3);
        check("bp2_op", 32'(opv), 32'd6);

        // Reset one cycle after accept on the latency-3 instance.
        @(negedge clk);
        Opcode = 6'h00; Funct = 6'h20; RsData = 32'h3; RtData = 32'h4; Imm = 16'h0;
        InValid3 = 1'b1;
        @(posedge clk);
        #1 InValid3 = 1'b0;
        check("r3_op_exec", 32'(Operation3), 32'd2);
        @(posedge clk);
        #1 rst3_n = 1'b0;
        #1;
        check("r3_inready",  32'(InReady3),   32'd1);
        check("r3_outvalid", 32'(OutValid3),  32'd0);
        check("r3_op",       32'(Operation3), 32'd15);
        check("r3_din1",     DataIn1_3,       32'd0);
        check("r3_din2",     DataIn2_3,       32'd0);
        check("r3_outres",   OutResult3,      32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (OutValid3) spurious++;
        end
        check("r3_no_rsp", 32'(spurious), 32'd0);
        Opcode = 6'h00; Funct = 6'h27; RsData = 32'h0; RtData = 32'h0;
        check("r3_inready_nor", 32'(InReady3), 32'd1);
        sb3_q.push_back('{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
        InValid3 = 1'b1;
        @(posedge clk);
        #1 InValid3 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!OutValid3 && n < 20);
        check("r3_nor_lat", 32'(n), 32'd5);
        @(negedge clk);
        @(negedge clk);

        check("sb_drained",  32'(sb_q.size()),  32'd0);
        check("sb3_drained", 32'(sb3_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
